// File: rtl/flash_arb_pkg.sv
// Shared types and constants for the two-requester Flash access arbiter.
package flash_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP,
        ST_DRAIN
    } arb_state_t;

    typedef struct packed {
        logic       rw;
        logic [7:0] addr;
        logic [7:0] wdata;
    } flash_req_t;

    localparam logic FLOW_READ       = 1'b0;
    localparam logic FLOW_WRITE      = 1'b1;
    localparam int   DEFAULT_TIMEOUT = 50000;

    // Round-robin pick: on contention the requester not served last wins.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        if (req0 && req1) begin
            return ~last;
        end
        return ~req0;
    endfunction

endpackage

// File: rtl/flash_timeout_ctr.sv
// Access watchdog: counts enabled cycles after a clear and flags expiry.
// Latency: expired rises one cycle after the count reaches TIMEOUT_CYCLES-1.
// Backpressure: none; the count saturates and holds until cleared.
module flash_timeout_ctr
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int            CW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Expiry is registered, so the abort lands on the cycle after the limit is hit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt     <= '0;
            expired <= 1'b0;
        end else if (en) begin
            if (cnt == LIMIT) begin
                expired <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/flash_arbiter.sv
// Round-robin share of one byte-wide Flash handshake between two requesters.
// Latency: REQ to DONE is 3 cycles minimum; a timeout aborts TIMEOUT_CYCLES+2 after FL_TRG.
// Backpressure: requests wait in IDLE while Flash still reports done or another access runs.
module flash_arbiter
    import flash_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic       CLK_50MHZ,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic       RW0,
    input  logic       RW1,
    input  logic [7:0] ADDR0,
    input  logic [7:0] ADDR1,
    input  logic [7:0] WDATA0,
    input  logic [7:0] WDATA1,
    output logic       DONE0,
    output logic       DONE1,
    output logic       ERR0,
    output logic       ERR1,
    output logic [7:0] RDATA,
    output logic       BUSY,
    output logic       FL_TRG,
    output logic       FL_FLOW,
    output logic [7:0] FL_ADDR,
    output logic [7:0] FL_DATA_OUT,
    input  logic [7:0] FL_DATA_IN,
    input  logic       FL_STATUS
);

    arb_state_t state, state_nxt;
    flash_req_t req_sel;
    logic       win_idx;
    logic       grant;
    logic       gnt_idx;
    logic       rr_last;
    logic       err_flag;
    logic       tmo_clr;
    logic       tmo_en;
    logic       tmo_expired;

    assign win_idx = rr_pick(REQ0, REQ1, rr_last);
    assign grant   = (state == ST_IDLE) && !FL_STATUS && (REQ0 || REQ1);

    always_comb begin
        req_sel = '0;
        if (win_idx) begin
            req_sel.rw    = RW1;
            req_sel.addr  = ADDR1;
            req_sel.wdata = WDATA1;
        end else begin
            req_sel.rw    = RW0;
            req_sel.addr  = ADDR0;
            req_sel.wdata = WDATA0;
        end
    end

    flash_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (CLK_50MHZ),
        .rst    (RST),
        .clr    (tmo_clr),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        FL_TRG    = 1'b0;
        BUSY      = (state != ST_IDLE);
        DONE0     = 1'b0;
        DONE1     = 1'b0;
        ERR0      = 1'b0;
        ERR1      = 1'b0;
        tmo_clr   = 1'b0;
        tmo_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                FL_TRG    = 1'b1;
                tmo_clr   = 1'b1;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                tmo_en = 1'b1;
                // Flash completion outranks a simultaneous expiry.
                if (FL_STATUS || tmo_expired) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                DONE0     = ~gnt_idx;
                DONE1     = gnt_idx;
                ERR0      = ~gnt_idx & err_flag;
                ERR1      = gnt_idx & err_flag;
                state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!FL_STATUS) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (RST) begin
            gnt_idx     <= 1'b0;
            rr_last     <= 1'b1;
            err_flag    <= 1'b0;
            RDATA       <= '0;
            FL_FLOW     <= FLOW_READ;
            FL_ADDR     <= '0;
            FL_DATA_OUT <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        gnt_idx     <= win_idx;
                        FL_FLOW     <= req_sel.rw;
                        FL_ADDR     <= req_sel.addr;
                        FL_DATA_OUT <= req_sel.wdata;
                    end
                end
                ST_WAIT: begin
                    if (FL_STATUS) begin
                        err_flag <= 1'b0;
                        if (FL_FLOW == FLOW_READ) begin
                            RDATA <= FL_DATA_IN;
                        end
                    end else if (tmo_expired) begin
                        err_flag <= 1'b1;
                    end
                end
                ST_RESP: begin
                    rr_last <= gnt_idx;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_arbiter.sv
// Directed and randomized bench for flash_arbiter against a transaction-level model.
module tb_flash_arbiter;

    localparam int TMO = 8;

    logic       CLK_50MHZ;
    logic       RST;
    logic [1:0] req_v;
    logic [1:0] rw_v;
    logic [7:0] addr_v  [2];
    logic [7:0] wdata_v [2];
    logic       DONE0, DONE1, ERR0, ERR1, BUSY;
    logic       FL_TRG, FL_FLOW;
    logic [7:0] RDATA, FL_ADDR, FL_DATA_OUT;
    logic [7:0] fl_data_in;
    logic       fl_status;

    int         n_pass;
    int         n_total;
    int         cyc;
    int         last_srv;
    int         last_done;
    logic [7:0] exp_rdata;
    logic       last_win_obs;

    flash_arbiter #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK_50MHZ  (CLK_50MHZ),
        .RST        (RST),
        .REQ0       (req_v[0]),
        .REQ1       (req_v[1]),
        .RW0        (rw_v[0]),
        .RW1        (rw_v[1]),
        .ADDR0      (addr_v[0]),
        .ADDR1      (addr_v[1]),
        .WDATA0     (wdata_v[0]),
        .WDATA1     (wdata_v[1]),
        .DONE0      (DONE0),
        .DONE1      (DONE1),
        .ERR0       (ERR0),
        .ERR1       (ERR1),
        .RDATA      (RDATA),
        .BUSY       (BUSY),
        .FL_TRG     (FL_TRG),
        .FL_FLOW    (FL_FLOW),
        .FL_ADDR    (FL_ADDR),
        .FL_DATA_OUT(FL_DATA_OUT),
        .FL_DATA_IN (fl_data_in),
        .FL_STATUS  (fl_status)
    );

    initial CLK_50MHZ = 1'b0;
    always #10 CLK_50MHZ = ~CLK_50MHZ;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK_50MHZ);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic raise(input int idx, input logic rw, input logic [7:0] addr, input logic [7:0] wdata);
        req_v[idx]   = 1'b1;
        rw_v[idx]    = rw;
        addr_v[idx]  = addr;
        wdata_v[idx] = wdata;
    endtask

    task automatic model_reset();
        last_srv  = 1;
        last_done = -100;
        exp_rdata = 8'h00;
    endtask

    // One arbitrated access. lat = cycles after FL_TRG at which Flash signals done; 0 = never.
    task automatic serve(input int lat, input logic [7:0] fdata);
        int         win;
        int         exp_trg;
        int         t;
        int         d;
        int         extra_trg;
        int         exp_off;
        bit         success;
        logic [1:0] exp_err;
        logic [16:0] snap;

        win     = (req_v[0] && req_v[1]) ? 1 - last_srv : (req_v[0] ? 0 : 1);
        exp_trg = (cyc + 1 > last_done + 3) ? cyc + 1 : last_done + 3;
        success = (lat >= 1) && (lat <= TMO + 1);
        exp_off = success ? lat + 1 : TMO + 2;
        exp_err = success ? 2'b00 : (win == 1 ? 2'b10 : 2'b01);

        t = -1;
        for (int i = 0; i < 24 && t < 0; i++) begin
            tick();
            if (FL_TRG === 1'b1) t = cyc;
        end
        chk("trg_cycle", t, exp_trg);
        if (t < 0) return;
        chk("busy_at_trg", BUSY, 1);
        chk("grant_fields", {FL_FLOW, FL_ADDR, FL_DATA_OUT}, {rw_v[win], addr_v[win], wdata_v[win]});
        snap = {FL_FLOW, FL_ADDR, FL_DATA_OUT};

        d = -1;
        extra_trg = 0;
        for (int i = 0; i < TMO + 6 && d < 0; i++) begin
            if (lat > 0 && cyc - t == lat) begin
                fl_status  = 1'b1;
                fl_data_in = fdata;
            end
            tick();
            if (FL_TRG !== 1'b0) extra_trg++;
            if (DONE0 === 1'b1 || DONE1 === 1'b1) d = cyc;
        end
        chk("done_latency", d - t, exp_off);
        chk("trg_single_pulse", extra_trg, 0);
        chk("done_owner", {DONE1, DONE0}, (win == 1) ? 2'b10 : 2'b01);
        chk("err_flag", {ERR1, ERR0}, exp_err);
        if (success && rw_v[win] == 1'b0) exp_rdata = fdata;
        chk("rdata", RDATA, exp_rdata);
        chk("fields_stable", {FL_FLOW, FL_ADDR, FL_DATA_OUT}, snap);

        last_win_obs = DONE1;
        fl_status    = 1'b0;
        fl_data_in   = 8'($urandom);
        req_v[win]   = 1'b0;
        last_srv     = win;
        last_done    = d;
        tick();
        chk("done_one_cycle", {DONE1, DONE0}, 2'b00);
    endtask

    initial begin
        int cnt;
        int t;
        int lat;
        int pick;

        n_pass = 0;
        n_total = 0;
        cyc = 0;
        RST = 1'b1;
        req_v = 2'b00;
        rw_v = 2'b00;
        addr_v[0] = 8'h00;
        addr_v[1] = 8'h00;
        wdata_v[0] = 8'h00;
        wdata_v[1] = 8'h00;
        fl_status = 1'b0;
        fl_data_in = 8'h77;
        last_win_obs = 1'b0;
        model_reset();

        tick();
        tick();
        chk("reset_ctrl", {FL_TRG, FL_FLOW, BUSY, DONE0, DONE1, ERR0, ERR1}, 7'b0);
        chk("reset_addr", FL_ADDR, 8'h00);
        chk("reset_dout", FL_DATA_OUT, 8'h00);
        chk("reset_rdata", RDATA, 8'h00);
        RST = 1'b0;
        tick();

        // Single read by requester 0
        raise(0, 1'b0, 8'h12, 8'h00);
        serve(4, 8'hA5);
        chk("read_rdata", RDATA, 8'hA5);

        // Single write by requester 1; RDATA must keep the previous read value
        raise(1, 1'b1, 8'h40, 8'h3C);
        serve(3, 8'hEE);
        chk("write_rdata_kept", RDATA, 8'hA5);

        // Contention: both rise together, each re-raised after its DONE
        raise(0, 1'b0, 8'h21, 8'h11);
        raise(1, 1'b1, 8'h81, 8'h99);
        for (int k = 0; k < 6; k++) begin
            serve(int'($urandom_range(1, 3)), 8'($urandom));
            chk("rr_order", last_win_obs, k % 2);
            if (k < 4) begin
                if (last_srv == 0) raise(0, 1'b0, 8'h21, 8'h11);
                else raise(1, 1'b1, 8'h81, 8'h99);
            end
        end

        // Timeout, then a normal access afterwards
        raise(0, 1'b0, 8'h33, 8'h00);
        serve(0, 8'h00);
        raise(1, 1'b0, 8'h34, 8'h00);
        serve(2, 8'hC3);

        // Flash done on the very last wait cycle: success must win
        raise(0, 1'b0, 8'h35, 8'h00);
        serve(TMO + 1, 8'h5A);

        // FL_STATUS held high in IDLE blocks the grant
        tick();
        fl_status = 1'b1;
        raise(0, 1'b1, 8'h36, 8'h47);
        cnt = 0;
        repeat (6) begin
            tick();
            if (FL_TRG !== 1'b0 || BUSY !== 1'b0) cnt++;
        end
        chk("status_gates_grant", cnt, 0);
        fl_status = 1'b0;
        serve(2, 8'h00);

        // Reset during WAIT, then a stale Flash done while requester 1 waits
        raise(0, 1'b0, 8'h50, 8'h00);
        t = -1;
        for (int i = 0; i < 10 && t < 0; i++) begin
            tick();
            if (FL_TRG === 1'b1) t = cyc;
        end
        chk("pre_reset_trg_seen", (t >= 0), 1);
        tick();
        tick();
        RST = 1'b1;
        tick();
        chk("midrst_ctrl", {FL_TRG, FL_FLOW, BUSY, DONE0, DONE1, ERR0, ERR1}, 7'b0);
        chk("midrst_addr", FL_ADDR, 8'h00);
        chk("midrst_rdata", RDATA, 8'h00);
        RST = 1'b0;
        req_v[0] = 1'b0;
        raise(1, 1'b0, 8'h66, 8'h00);
        fl_status = 1'b1;
        model_reset();
        cnt = 0;
        repeat (5) begin
            tick();
            if (FL_TRG !== 1'b0 || DONE0 !== 1'b0 || DONE1 !== 1'b0 || BUSY !== 1'b0) cnt++;
        end
        chk("midrst_blocked", cnt, 0);
        fl_status = 1'b0;
        serve(2, 8'h9D);

        // Randomized traffic
        for (int n = 0; n < 24; n++) begin
            if (req_v == 2'b00) begin
                pick = int'($urandom_range(1, 3));
                if (pick[0]) raise(0, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
                if (pick[1]) raise(1, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
            end else if ($urandom_range(0, 1) == 1) begin
                if (!req_v[0]) raise(0, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
                else raise(1, $urandom_range(0, 1) == 1, 8'($urandom), 8'($urandom));
            end
            lat = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TMO + 1));
            serve(lat, 8'($urandom));
        end
        while (req_v != 2'b00) serve(1, 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/flash_arbiter.md
# flash_arbiter

- Shares the single byte-wide Flash controller handshake (trigger, done, direction, address, data) between two requesters.
  - Requester 0 is the UART command manager.
  - Requester 1 is the scoreboard display refresher.
- Grants one access at a time, round-robin, and sequences the trigger/done handshake for the granted requester.
- Guards each access with a timeout and returns a per-requester done pulse, read data and error flag.
- Sits between MANAGER-class clients and the Flash module.

## Interface

Parameters:

- TIMEOUT_CYCLES, 50000, cycles allowed from trigger to Flash done before abort (1 ms at 50 MHz); minimum 2.

Ports:

- CLK_50MHZ  in  1  sole clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0, REQ1  in  1 each  access request; level, held until matching DONE.
- RW0, RW1  in  1 each  1 = write, 0 = read.
- ADDR0, ADDR1  in  8 each  flash byte address.
- WDATA0, WDATA1  in  8 each  write data; ignored on read.
- DONE0, DONE1  out  1 each  one-cycle completion pulse.
- ERR0, ERR1  out  1 each  timeout flag; valid only with the matching DONE.
- RDATA  out  8  read data; valid on a DONE cycle of a successful read.
- BUSY  out  1  high whenever state is not IDLE.
- FL_TRG  out  1  one-cycle start pulse to Flash.
- FL_FLOW  out  1  direction to Flash (1 = write).
- FL_ADDR  out  8  address to Flash.
- FL_DATA_OUT  out  8  write data to Flash.
- FL_DATA_IN  in  8  read data from Flash.
- FL_STATUS  in  1  Flash done; high on completion, low again before the next access.

## Operation

- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - Grants only when FL_STATUS = 0 and at least one REQ is high.
  - Winner is chosen round-robin:
    - If both REQs are high, the requester not served last wins.
    - Pointer resets to "1 served last", so requester 0 wins first.
  - Latches the winner's RW/ADDR/WDATA into FL_FLOW/FL_ADDR/FL_DATA_OUT and records the grant index; next state ISSUE.
- ISSUE:
  - FL_TRG = 1 for exactly this cycle.
  - Timeout counter cleared to 0.
  - Next state WAIT.
- WAIT, evaluated in priority order:
  - FL_STATUS = 1: capture FL_DATA_IN into RDATA on reads only (RDATA unchanged on writes); clear the error flag; next state RESP.
  - Else, counter = TIMEOUT_CYCLES-1: set the error flag; RDATA unchanged; next state RESP.
  - Else: increment counter.
- RESP:
  - DONE of the granted requester = 1 for one cycle.
  - ERR of the granted requester = error flag.
  - Round-robin pointer updated to the granted index.
  - Next state DRAIN.
- DRAIN: hold until FL_STATUS = 0, then IDLE.
- FL_FLOW, FL_ADDR and FL_DATA_OUT stay stable from the IDLE latch until the next grant; they never change mid-access.
- Requester obligations:
  - Keep inputs stable while REQ is high.
  - Drop REQ in the cycle after DONE.
  - A REQ still high when IDLE is re-entered is treated as a new request.
- Ungranted REQ inputs have no effect.
- Counter width is clog2(TIMEOUT_CYCLES); no wrap, because it saturates at the compare value.

## Timing

- Reset:
  - State IDLE.
  - FL_TRG, FL_FLOW, FL_ADDR, FL_DATA_OUT, DONE0/1, ERR0/1, RDATA and BUSY all 0.
  - Round-robin pointer = 1.
- REQ sampled high at edge k (IDLE, FL_STATUS = 0):
  - FL_TRG high during cycle k+1.
  - BUSY high from cycle k+1.
- FL_STATUS first sampled high at edge m in WAIT: DONE and RDATA valid during cycle m+1.
- Minimum latency, REQ to DONE: 3 cycles when Flash responds in the first WAIT cycle.
- Timeout: DONE with ERR fires TIMEOUT_CYCLES+2 cycles after FL_TRG.
- Minimum back-to-back spacing: DONE at cycle d, next FL_TRG no earlier than d+3 (DRAIN, IDLE, ISSUE).
- FL_STATUS high in IDLE blocks granting; this covers a Flash completion arriving after a reset mid-operation.
- Reset during WAIT: FL_TRG stays low; no DONE is issued for the aborted access; requests are re-arbitrated afresh.
- FL_STATUS high in the same cycle the counter hits its limit: success wins, ERR = 0.

## Structure

- Package flash_arb_pkg holds:
  - the state enum;
  - FLOW_READ = 0 and FLOW_WRITE = 1;
  - DEFAULT_TIMEOUT = 50000.
- One natural sub-module: flash_timeout_ctr, a clear/enable/expire counter parameterized by TIMEOUT_CYCLES.
- Arbitration and the FSM stay in flash_arbiter.

## Test plan

- Single read: REQ0, RW0 = 0, ADDR0 = 0x12; Flash returns 0xA5 with FL_STATUS 4 cycles after FL_TRG.
  - Required: FL_ADDR = 0x12, FL_FLOW = 0, one FL_TRG pulse, DONE0 one cycle, RDATA = 0xA5, ERR0 = 0, DONE1 never.
- Single write: REQ1, RW1 = 1, ADDR1 = 0x40, WDATA1 = 0x3C.
  - Required: FL_FLOW = 1, FL_DATA_OUT = 0x3C held stable until DONE1; RDATA unchanged.
- Contention: REQ0 and REQ1 rise in the same cycle and are each re-raised after DONE, three times.
  - Required grant order 0, 1, 0, 1, 0, 1; FL_TRG pulses spaced at least 3 cycles after each DONE.
- Timeout: TIMEOUT_CYCLES = 8; FL_STATUS never asserts.
  - Required: DONE0 with ERR0 = 1 exactly 10 cycles after FL_TRG; return to IDLE; the next request is served normally.
- Reset mid-access: RST in WAIT, then Flash raises FL_STATUS for 5 cycles while REQ1 is pending.
  - Required: all outputs 0 after reset; no DONE for the aborted access; FL_TRG for requester 1 only after FL_STATUS falls.
- Collision and gating: FL_STATUS rises on the same cycle the counter reaches its limit, and is held high in IDLE with REQ0 pending.
  - Required: first case ERR = 0; second case no grant until FL_STATUS = 0.
